// File: rtl/key_encoder.sv
// Keypad-to-note encoder: synchronizes the raw key lines and emits octave*7 + key + 1.
// Define KEY_ENCODER_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES-long stability filter before encoding.
module key_encoder #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic       clk_5MHz,
   input  logic       rst_n,
   input  logic [9:0] IOs,
   output logic [4:0] notecode
);

   if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > 65535)) begin : g_bad_param
      $error("key_encoder: DEBOUNCE_CYCLES out of range 2..65535");
   end

   logic [9:0] sync1_r;
   logic [9:0] sync2_r;
   logic [9:0] pattern_s;
   logic [4:0] notecode_r;

   // Octave priority is high-first, key priority is lowest-bit-first.
   function automatic logic [4:0] encode(input logic [9:0] p);
      logic [4:0] base;
      logic [4:0] key;
      logic       has_oct;
      logic       has_key;
      has_oct = 1'b1;
      has_key = 1'b1;
      casez (p[9:7])
         3'b1??:  base = 5'd14;
         3'b01?:  base = 5'd7;
         3'b001:  base = 5'd0;
         default: begin
            base    = 5'd0;
            has_oct = 1'b0;
         end
      endcase
      casez (p[6:0])
         7'b??????1: key = 5'd0;
         7'b?????10: key = 5'd1;
         7'b????100: key = 5'd2;
         7'b???1000: key = 5'd3;
         7'b??10000: key = 5'd4;
         7'b?100000: key = 5'd5;
         7'b1000000: key = 5'd6;
         default: begin
            key     = 5'd0;
            has_key = 1'b0;
         end
      endcase
      if (has_oct && has_key) begin
         encode = base + key + 5'd1;
      end else begin
         encode = 5'd0;
      end
   endfunction

   // Two-flop synchronizer for the asynchronous key lines.
   always_ff @(posedge clk_5MHz or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 10'd0;
         sync2_r <= 10'd0;
      end else begin
         sync1_r <= IOs;
         sync2_r <= sync1_r;
      end
   end

`ifdef KEY_ENCODER_DEBOUNCE_EN
   // Acceptance fires on the edge where the count reaches DEBOUNCE_CYCLES-1.
   localparam logic [15:0] ACCEPT_AT = 16'(DEBOUNCE_CYCLES - 2);

   logic [9:0]  candidate_r;
   logic [9:0]  accepted_r;
   logic [15:0] count_r;

   // Candidate tracking, stability counting and acceptance.
   always_ff @(posedge clk_5MHz or negedge rst_n) begin
      if (!rst_n) begin
         candidate_r <= 10'd0;
         accepted_r  <= 10'd0;
         count_r     <= 16'd0;
      end else if (sync2_r != candidate_r) begin
         candidate_r <= sync2_r;
         count_r     <= 16'd0;
      end else if (count_r == ACCEPT_AT) begin
         accepted_r  <= candidate_r;
         count_r     <= count_r + 16'd1;
      end else if (count_r < ACCEPT_AT) begin
         count_r     <= count_r + 16'd1;
      end else begin
         count_r     <= count_r;
      end
   end

   assign pattern_s = accepted_r;
`else
   assign pattern_s = sync2_r;
`endif

   // Output register: notecode only moves on a clock edge.
   always_ff @(posedge clk_5MHz or negedge rst_n) begin
      if (!rst_n) begin
         notecode_r <= 5'd0;
      end else begin
         notecode_r <= encode(pattern_s);
      end
   end

   assign notecode = notecode_r;

endmodule

// File: tb/tb_key_encoder.sv
// Self-checking bench for key_encoder: vector table with an expected-value queue plus reset and debounce sequences.
module tb_key_encoder;

   localparam int N = 8;
`ifdef KEY_ENCODER_DEBOUNCE_EN
   localparam int LAT = 3 + N;
`else
   localparam int LAT = 3;
`endif
   localparam int HOLD = 20;
   localparam int NV   = 15;

   typedef struct {
      logic [9:0] ios;
      logic [4:0] exp;
   } vec_t;

   logic       clk_5MHz = 1'b0;
   logic       rst_n;
   logic [9:0] IOs;
   logic [4:0] notecode;

   vec_t       vecs [NV];
   logic [4:0] exp_q [$];
   logic [4:0] prev_exp;
   logic [4:0] want;
   int         pass_cnt = 0;
   int         total_cnt = 0;

   always #5 clk_5MHz = ~clk_5MHz;

   key_encoder #(.DEBOUNCE_CYCLES(N)) dut (
      .clk_5MHz(clk_5MHz),
      .rst_n   (rst_n),
      .IOs     (IOs),
      .notecode(notecode)
   );

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: notecode=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk_5MHz);
      #1;
   endtask

   // Drive a pattern, check old value one edge early, then the queued expectation exactly at latency.
   task automatic apply(input string name, input logic [9:0] ios, input logic [4:0] exp);
      @(negedge clk_5MHz);
      IOs = ios;
      exp_q.push_back(exp);
      wait_edges(LAT - 1);
      check({name, "_early"}, notecode, prev_exp);
      wait_edges(1);
      want = exp_q.pop_front();
      check(name, notecode, want);
      prev_exp = want;
   endtask

   initial begin
      vecs[0]  = '{10'b001_0000001, 5'd1};
      vecs[1]  = '{10'b001_0000010, 5'd2};
      vecs[2]  = '{10'b010_0000001, 5'd8};
      vecs[3]  = '{10'b010_0000010, 5'd9};
      vecs[4]  = '{10'b100_0000001, 5'd15};
      vecs[5]  = '{10'b100_0000010, 5'd16};
      vecs[6]  = '{10'b000_1000000, 5'd0};
      vecs[7]  = '{10'b100_0000000, 5'd0};
      vecs[8]  = '{10'b110_1000100, 5'd17};
      vecs[9]  = '{10'b001_1000000, 5'd7};
      vecs[10] = '{10'b011_0100000, 5'd13};
      vecs[11] = '{10'b111_1111111, 5'd15};
      vecs[12] = '{10'b100_1000000, 5'd21};
      vecs[13] = '{10'b001_0000100, 5'd3};
      vecs[14] = '{10'b000_0000000, 5'd0};

      IOs   = 10'd0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #3 check("reset", notecode, 5'd0);
      @(negedge clk_5MHz);
      rst_n = 1'b1;
      wait_edges(LAT + 2);
      check("idle", notecode, 5'd0);
      prev_exp = 5'd0;

      for (int i = 0; i < NV; i++) begin
         apply($sformatf("vec%0d", i), vecs[i].ios, vecs[i].exp);
         repeat (HOLD - LAT) @(posedge clk_5MHz);
      end

      apply("pre_reset", 10'b100_1000000, 5'd21);
      repeat (HOLD - LAT) @(posedge clk_5MHz);
      @(negedge clk_5MHz);
      #2 rst_n = 1'b0;
      #1 check("async_reset", notecode, 5'd0);
      @(negedge clk_5MHz);
      rst_n = 1'b1;
      exp_q.push_back(5'd21);
      prev_exp = 5'd0;
      wait_edges(LAT - 1);
      check("post_reset_early", notecode, prev_exp);
      wait_edges(1);
      want = exp_q.pop_front();
      check("post_reset", notecode, want);
      prev_exp = want;

      apply("back_to_zero", 10'd0, 5'd0);
      repeat (HOLD - LAT) @(posedge clk_5MHz);

`ifdef KEY_ENCODER_DEBOUNCE_EN
      @(negedge clk_5MHz);
      IOs = 10'b010_0000001;
      repeat (5) @(negedge clk_5MHz);
      IOs = 10'd0;
      for (int c = 0; c < 20; c++) begin
         wait_edges(1);
         check($sformatf("short_pulse_c%0d", c), notecode, 5'd0);
      end
      apply("debounced_hold", 10'b010_0000001, 5'd8);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/key_encoder.md
KEY_ENCODER -- requirements
Module: key_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, is the number of consecutive stable clk_5MHz cycles needed to accept a new key pattern when debounce is compiled in (10 ms at 5 MHz); legal range 2..65535.
REQ-002 Port clk_5MHz, input, 1 bit: the 5 MHz system clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port IOs, input, 10 bits: raw asynchronous key lines; IOs[9:7] select the octave, IOs[6:0] are the note keys; a line is active-high.
REQ-005 Port notecode, output, 5 bits, registered: encoded note; 0 means silence.

Function
REQ-006 IOs SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-007 Octave index SHALL be 2 when IOs[9] is set (high); else 1 when IOs[8] is set (medium); else 0 when IOs[7] is set (low); else there is no octave.
REQ-008 Key index SHALL be the lowest set bit of IOs[6:0]: bit0 = 0 (Do), bit1 = 1 (Re), up to bit6 = 6 (Si).
REQ-009 The encoder SHALL compute notecode = octave*7 + key + 1.
- Codes 1..7: low octave.
- Codes 8..14: medium octave.
- Codes 15..21: high octave.
REQ-010 notecode SHALL be 0 when no octave bit is set or no key bit is set.
REQ-011 Codes 22..31 SHALL never be produced.
REQ-012 When debounce is not compiled in, notecode SHALL update exactly 3 clock edges after an IOs change: 2 synchronizer edges plus 1 output register edge.
REQ-013 Multiple simultaneous bits SHALL resolve by priority per REQ-007/REQ-008.
- Highest octave wins.
- Lowest key wins.
- No error flag is produced.
REQ-014 notecode SHALL hold its value while the synchronized input is unchanged; it SHALL never glitch between edges.

Reset
REQ-015 While rst_n = 0, the following SHALL be cleared asynchronously:
- notecode = 0.
- Synchronizer flops = 0.
- Debounce counter = 0.
- Debounce stable-pattern register = 0.
REQ-016 After rst_n deasserts, the first valid notecode SHALL follow the normal latency rules; reset asserted mid-count discards the pending pattern.

Configuration
REQ-017 Macro KEY_ENCODER_DEBOUNCE_EN: when defined, a debounce stage SHALL sit between the synchronizer and the encoder.
- The stage compares the synchronized pattern with the last candidate.
- Any difference reloads the counter to 0 and stores the new candidate.
- When the counter reaches DEBOUNCE_CYCLES-1 with the pattern unchanged, the candidate becomes the accepted pattern; encoding is then registered on the next edge.
- notecode latency SHALL be 3 + DEBOUNCE_CYCLES edges after a stable change.
- A change lasting fewer than DEBOUNCE_CYCLES cycles SHALL leave notecode unchanged.
REQ-018 When KEY_ENCODER_DEBOUNCE_EN is undefined, no counter logic SHALL exist and REQ-012 latency applies.

Verification
REQ-019 Set IOs=10'b001_0000001, 10'b001_0000010, 10'b010_0000001, 10'b010_0000010, 10'b100_0000001, 10'b100_0000010, each held 20 clocks -> notecode 1, 2, 8, 9, 15, 16, each appearing 3 edges after the change.
REQ-020 Set IOs=10'b000_1000000 (key, no octave), then 10'b100_0000000 (octave, no key) -> notecode 0 in both cases.
REQ-021 Set IOs=10'b110_1000100 -> notecode 17 (high octave, Mi); set IOs=10'b001_1000000 -> notecode 7.
REQ-022 Hold IOs=10'b100_1000000 (notecode 21), then assert rst_n=0 between clock edges -> notecode 0 immediately, without waiting for an edge; after release -> notecode 21 three edges later.
REQ-023 With KEY_ENCODER_DEBOUNCE_EN defined and DEBOUNCE_CYCLES=8:
- A 5-cycle pulse of 10'b010_0000001 leaves notecode 0.
- Holding 10'b010_0000001 gives notecode 8 after 11 edges.
